axi4_burst_mem: RTL

- Parametrised AXI4 slave memory; successor to the current single-mode AXI4 memory slave.
- Adds FIXED/INCR/WRAP bursts, WSTRB byte-lane writes, RLAST, per-beat out-of-range error reporting, and a data-width-generic address map.
- Sits behind the AXI4 interconnect as a word-addressed RAM target. Exercised by the existing AXI4 directed/random bench through the `axi4_if` slave modport.

---
 rtl/axi4_burst_mem.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_mem.sv
// AXI4 slave RAM: FIXED/INCR/WRAP bursts, WSTRB byte lanes, RLAST, per-beat SLVERR.
// Define AXI4_MEM_WRAP_EN to support WRAP bursts; otherwise WRAP is an illegal burst.
module axi4_burst_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEMORY_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic     run;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [ADDR_WIDTH-1:0] aw_addr, aw_step;
  logic [7:0]            aw_len, w_cnt;
  logic [1:0]            aw_burst;
  logic                  aw_err, w_flag, aw_bad, aw_oor, w_beat_err, w_last_beat;

  logic [ADDR_WIDTH-1:0] ar_addr, ar_step, r_addr;
  logic [7:0]            ar_len, r_cnt;
  logic [1:0]            ar_burst;
  logic                  ar_err, ar_bad, r_err, r_oor, r_load;

`ifdef AXI4_MEM_WRAP_EN
  logic [ADDR_WIDTH-1:0] aw_wmask, ar_wmask;
  assign aw_wmask = ADDR_WIDTH'(((32'(aw_len) + 32'd1) << LSB) - 32'd1);
  assign ar_wmask = ADDR_WIDTH'(((32'(ar_len) + 32'd1) << LSB) - 32'd1);
`endif

  // Burst legality, decided once at the address handshake.
  always_comb begin
    aw_bad = (AWSIZE != 3'(LSB));
    case (AWBURST)
      2'b00, 2'b01: ;
`ifdef AXI4_MEM_WRAP_EN
      2'b10: if (!(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15})) aw_bad = 1'b1;
`endif
      default: aw_bad = 1'b1;
    endcase
  end

  always_comb begin
    ar_bad = (ARSIZE != 3'(LSB));
    case (ARBURST)
      2'b00, 2'b01: ;
`ifdef AXI4_MEM_WRAP_EN
      2'b10: if (!(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_bad = 1'b1;
`endif
      default: ar_bad = 1'b1;
    endcase
  end

  always_comb begin
    aw_step = aw_addr;
    case (aw_burst)
      2'b01: aw_step = aw_addr + ADDR_WIDTH'(STRB_W);
`ifdef AXI4_MEM_WRAP_EN
      2'b10: aw_step = (aw_addr & ~aw_wmask) | ((aw_addr + ADDR_WIDTH'(STRB_W)) & aw_wmask);
`endif
      default: aw_step = aw_addr;
    endcase
  end

  always_comb begin
    ar_step = ar_addr;
    case (ar_burst)
      2'b01: ar_step = ar_addr + ADDR_WIDTH'(STRB_W);
`ifdef AXI4_MEM_WRAP_EN
      2'b10: ar_step = (ar_addr & ~ar_wmask) | ((ar_addr + ADDR_WIDTH'(STRB_W)) & ar_wmask);
`endif
      default: ar_step = ar_addr;
    endcase
  end

  assign aw_oor      = (32'(aw_addr) >> LSB) >= 32'(MEMORY_DEPTH);
  assign w_last_beat = (w_cnt == aw_len);
  assign w_beat_err  = aw_oor || (WLAST != w_last_beat);

  // run gates the readies so they stay low in reset and rise one edge after release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      run     <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      run     <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = run;
        if (AWVALID && run) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_burst <= '0;
      aw_err   <= 1'b0;
      w_flag   <= 1'b0;
      w_cnt    <= '0;
      BRESP    <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (AWVALID && AWREADY) begin
          aw_addr  <= AWADDR;
          aw_len   <= AWLEN;
          aw_burst <= AWBURST;
          aw_err   <= aw_bad;
          w_flag   <= 1'b0;
          w_cnt    <= '0;
        end
        W_DATA: if (WVALID) begin
          aw_addr <= aw_step;
          w_cnt   <= w_cnt + 8'd1;
          w_flag  <= w_flag | w_beat_err;
          if (w_last_beat)
            BRESP <= (aw_err || w_flag || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
        W_RESP: if (BREADY) BRESP <= RESP_OKAY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_state == W_DATA && WVALID && !aw_err && !aw_oor) begin
      for (int unsigned b = 0; b < STRB_W; b++)
        if (WSTRB[b]) mem[aw_addr[LSB +: IDX_W]][8*b +: 8] <= WDATA[8*b +: 8];
    end
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = run;
        if (ARVALID && run) r_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && RLAST) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // One load path serves both the first beat (from AR) and each following beat.
  assign r_addr = (r_state == R_IDLE) ? ARADDR : ar_step;
  assign r_err  = (r_state == R_IDLE) ? ar_bad : ar_err;
  assign r_oor  = (32'(r_addr) >> LSB) >= 32'(MEMORY_DEPTH);
  assign r_load = (r_state == R_IDLE) ? (ARVALID && ARREADY) : (RREADY && !RLAST);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_burst <= '0;
      ar_err   <= 1'b0;
      r_cnt    <= '0;
      RDATA    <= '0;
      RRESP    <= RESP_OKAY;
      RLAST    <= 1'b0;
    end else if (r_load) begin
      ar_addr <= r_addr;
      ar_err  <= r_err;
      if (r_state == R_IDLE) begin
        ar_len   <= ARLEN;
        ar_burst <= ARBURST;
        r_cnt    <= '0;
        RLAST    <= (ARLEN == 8'd0);
      end else begin
        r_cnt <= r_cnt + 8'd1;
        RLAST <= (r_cnt + 8'd1 == ar_len);
      end
      if (r_err || r_oor) begin
        RDATA <= '0;
        RRESP <= RESP_SLVERR;
      end else begin
        RDATA <= mem[r_addr[LSB +: IDX_W]];
        RRESP <= RESP_OKAY;
      end
    end else if (r_state == R_DATA && RREADY) begin
      RDATA <= '0;
      RRESP <= RESP_OKAY;
      RLAST <= 1'b0;
    end
  end

endmodule
